// File: rtl/wi23_defs.sv
// Shared definitions for the wi23 keyboard path: bus width, decoder entry width
// and the strobe edge-detector state type.
package wi23_defs;

  localparam int DATA_WIDTH = 32;
  localparam int KB_ENTRY_W = 18;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } edge_state_t;

endpackage

// File: rtl/kb_char_ram.sv
// Keyboard character storage: DEPTH x DATA_WIDTH register file with one
// synchronous write port and an asynchronous read port.
module kb_char_ram
  import wi23_defs::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/kb_char_fifo.sv
// Keyboard character FIFO between the PS/2 decoder and the memory-mapped read
// port: edge-triggered push/pop strobes, overflow policy, break filtering, flush.
module kb_char_fifo
  import wi23_defs::*;
#(
  parameter int DEPTH       = 4,
  parameter int ENTRY_W     = KB_ENTRY_W,
  parameter int AF_LEVEL    = DEPTH - 1,
  parameter int DROP_OLDEST = 0,
  parameter int KEEP_BREAK  = 1,
  localparam int AW         = $clog2(DEPTH),
  localparam int CW         = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_i,
  input  logic                  read_i,
  input  logic                  make_i,
  input  logic [ENTRY_W-1:0]    entry_i,
  input  logic                  flush_i,
  output logic [DATA_WIDTH-1:0] entry_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  almost_full_o,
  output logic [CW-1:0]         count_o,
  output logic                  overflow_o
);

  localparam logic [CW-1:0] AF_CNT = CW'(AF_LEVEL);
  localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);

  edge_state_t           wr_state, rd_state;
  logic [AW:0]           wptr, rptr;
  logic                  push_ev, pop_ev, push_ok;
  logic                  is_empty, is_full, overflow_ev, mem_we, rptr_adv;
  logic [DATA_WIDTH-1:0] wr_word, head_word;

  assign push_ev  = (wr_state == IDLE) && write_i;
  assign pop_ev   = (rd_state == IDLE) && read_i;
  assign push_ok  = push_ev && !(&entry_i) && ((KEEP_BREAK != 0) || make_i);
  assign is_empty = (wptr == rptr);
  assign is_full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign wr_word  = DATA_WIDTH'({make_i, entry_i});

  // A pop on the same edge frees the head slot, so only an unaccompanied push overflows.
  assign overflow_ev = push_ok && is_full && !pop_ev;
  assign mem_we      = !rst && !flush_i && push_ok && (!overflow_ev || (DROP_OLDEST != 0));
  assign rptr_adv    = (pop_ev && !is_empty) || (overflow_ev && (DROP_OLDEST != 0));

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state <= IDLE;
      rd_state <= IDLE;
    end else begin
      case (wr_state)
        IDLE:    if (write_i) wr_state <= HELD;
        HELD:    if (!write_i) wr_state <= IDLE;
        default: wr_state <= IDLE;
      endcase
      case (rd_state)
        IDLE:    if (read_i) rd_state <= HELD;
        HELD:    if (!read_i) rd_state <= IDLE;
        default: rd_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wptr       <= '0;
      rptr       <= '0;
      entry_o    <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (pop_ev) entry_o <= is_empty ? '0 : head_word;
      if (mem_we) wptr <= wptr + PTR_ONE;
      if (rptr_adv) rptr <= rptr + PTR_ONE;
      if (overflow_ev) overflow_o <= 1'b1;
    end
  end

  kb_char_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wptr[AW-1:0]),
    .wdata (wr_word),
    .raddr (rptr[AW-1:0]),
    .rdata (head_word)
  );

  assign empty_o       = is_empty;
  assign full_o        = is_full;
  assign count_o       = CW'(wptr - rptr);
  assign almost_full_o = (count_o >= AF_CNT);

endmodule

// File: tb/tb_kb_char_fifo.sv
// Scoreboard bench for kb_char_fifo: two configurations share one stimulus stream
// and are checked against a queue-level reference model every cycle.
module tb_kb_char_fifo;
  import wi23_defs::*;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] ent;
    logic [2:0]  cnt;
    logic        emp;
    logic        ful;
    logic        af;
    logic        ovf;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst, write_i, read_i, make_i, flush_i;
  logic [17:0] entry_i;

  logic [DATA_WIDTH-1:0] entry0, entry1;
  logic [2:0]            count0, count1;
  logic                  empty0, full0, af0, ovf0;
  logic                  empty1, full1, af1, ovf1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  kb_char_fifo #(
    .DEPTH(DEPTH), .ENTRY_W(18), .AF_LEVEL(DEPTH - 1), .DROP_OLDEST(0), .KEEP_BREAK(1)
  ) dut0 (
    .clk(clk), .rst(rst), .write_i(write_i), .read_i(read_i), .make_i(make_i),
    .entry_i(entry_i), .flush_i(flush_i), .entry_o(entry0), .empty_o(empty0),
    .full_o(full0), .almost_full_o(af0), .count_o(count0), .overflow_o(ovf0)
  );

  kb_char_fifo #(
    .DEPTH(DEPTH), .ENTRY_W(18), .AF_LEVEL(DEPTH - 1), .DROP_OLDEST(1), .KEEP_BREAK(0)
  ) dut1 (
    .clk(clk), .rst(rst), .write_i(write_i), .read_i(read_i), .make_i(make_i),
    .entry_i(entry_i), .flush_i(flush_i), .entry_o(entry1), .empty_o(empty1),
    .full_o(full1), .almost_full_o(af1), .count_o(count1), .overflow_o(ovf1)
  );

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0h, required %0h", name, $time, got, want);
    end
  endtask

  // Reference model: each configuration is an ordered list, index 0 is the oldest entry.
  logic [31:0] mlist [2][DEPTH];
  int          mcnt [2];
  logic [31:0] mout [2];
  logic        movf [2];
  logic        prev_w = 1'b0;
  logic        prev_r = 1'b0;
  obs_t        eq0 [$];
  obs_t        eq1 [$];

  always @(posedge clk) begin : model_blk
    logic        pe, po, ok;
    logic [31:0] word;
    obs_t        o;
    pe = write_i && !prev_w;
    po = read_i && !prev_r;
    prev_w = rst ? 1'b0 : write_i;
    prev_r = rst ? 1'b0 : read_i;
    word = {13'b0, make_i, entry_i};
    for (int d = 0; d < 2; d++) begin
      if (rst || flush_i) begin
        mcnt[d] = 0;
        mout[d] = '0;
        movf[d] = 1'b0;
      end else begin
        ok = pe && (entry_i != 18'h3FFFF) && ((d == 0) || make_i);
        if (po) begin
          if (mcnt[d] > 0) begin
            mout[d] = mlist[d][0];
            for (int i = 0; i < DEPTH - 1; i++) mlist[d][i] = mlist[d][i+1];
            mcnt[d] = mcnt[d] - 1;
          end else begin
            mout[d] = '0;
          end
        end
        if (ok) begin
          if (mcnt[d] < DEPTH) begin
            mlist[d][mcnt[d]] = word;
            mcnt[d] = mcnt[d] + 1;
          end else begin
            movf[d] = 1'b1;
            if (d == 1) begin
              for (int i = 0; i < DEPTH - 1; i++) mlist[d][i] = mlist[d][i+1];
              mlist[d][DEPTH-1] = word;
            end
          end
        end
      end
      o.ent = mout[d];
      o.cnt = 3'(mcnt[d]);
      o.emp = (mcnt[d] == 0);
      o.ful = (mcnt[d] == DEPTH);
      o.af  = (mcnt[d] >= DEPTH - 1);
      o.ovf = movf[d];
      if (d == 0) eq0.push_back(o);
      else eq1.push_back(o);
    end
  end

  always @(negedge clk) begin : monitor_blk
    obs_t got;
    if (eq0.size() > 0) begin
      got = {entry0, count0, empty0, full0, af0, ovf0};
      checkOutput("dut0 {entry,count,empty,full,af,ovf}", 64'(got), 64'(eq0.pop_front()));
    end
    if (eq1.size() > 0) begin
      got = {entry1, count1, empty1, full1, af1, ovf1};
      checkOutput("dut1 {entry,count,empty,full,af,ovf}", 64'(got), 64'(eq1.pop_front()));
    end
  end

  // Drives one stimulus set, holds it for 'hold' edges; flush never outlives one call.
  task automatic applyStimulus(input logic w, input logic r, input logic fl, input logic mk,
                               input logic [17:0] e, input int hold);
    write_i = w;
    read_i  = r;
    flush_i = fl;
    make_i  = mk;
    entry_i = e;
    repeat (hold) @(posedge clk);
    #1;
    flush_i = 1'b0;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 18'h0, 1);
  endtask

  task automatic pushEntry(input logic [17:0] e, input logic mk, input int hold);
    applyStimulus(1'b1, 1'b0, 1'b0, mk, e, hold);
    idle();
  endtask

  task automatic popEntry();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 18'h0, 1);
    idle();
  endtask

  task automatic flushAll();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 18'h0, 1);
    idle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; write_i = 1'b0; read_i = 1'b0; make_i = 1'b0; flush_i = 1'b0; entry_i = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle();

    popEntry();
    checkOutput("pop on empty entry_o", 64'(entry0), 64'h0);
    checkOutput("pop on empty count_o", 64'(count0), 64'd0);
    checkOutput("pop on empty empty_o", 64'(empty0), 64'd1);

    pushEntry(18'h00041, 1'b1, 3);
    pushEntry(18'h00042, 1'b0, 3);
    checkOutput("held strobes count_o", 64'(count0), 64'd2);
    checkOutput("break filtered count_o", 64'(count1), 64'd1);
    popEntry();
    checkOutput("first pop make word", 64'(entry0), 64'h40041);
    popEntry();
    checkOutput("second pop break word", 64'(entry0), 64'h00042);
    checkOutput("filtered pop on empty", 64'(entry1), 64'h0);

    pushEntry(18'h3FFFF, 1'b1, 1);
    checkOutput("all-ones entry ignored", 64'(count0), 64'd0);
    pushEntry(18'h00043, 1'b0, 1);
    checkOutput("break kept count_o", 64'(count0), 64'd1);
    checkOutput("break dropped count_o", 64'(count1), 64'd0);
    popEntry();

    for (int i = 0; i < 5; i++) pushEntry(18'h00061 + 18'(i), 1'b1, 1);
    checkOutput("five pushes full_o", 64'(full0), 64'd1);
    checkOutput("five pushes overflow_o", 64'(ovf0), 64'd1);
    checkOutput("drop-oldest overflow_o", 64'(ovf1), 64'd1);
    for (int i = 0; i < 4; i++) begin
      popEntry();
      checkOutput("drop-newest pop order", 64'(entry0), 64'h40061 + 64'(i));
      checkOutput("drop-oldest pop order", 64'(entry1), 64'h40062 + 64'(i));
    end

    flushAll();
    checkOutput("flush clears overflow_o", 64'(ovf0), 64'd0);
    for (int i = 0; i < 4; i++) pushEntry(18'h00071 + 18'(i), 1'b1, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 18'h00075, 1);
    idle();
    checkOutput("full push+pop entry_o", 64'(entry0), 64'h40071);
    checkOutput("full push+pop count_o", 64'(count0), 64'd4);
    checkOutput("full push+pop overflow_o", 64'(ovf0), 64'd0);
    checkOutput("full push+pop count_o dut1", 64'(count1), 64'd4);

    flushAll();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 18'h00076, 1);
    idle();
    checkOutput("empty push+pop entry_o", 64'(entry0), 64'h0);
    checkOutput("empty push+pop count_o", 64'(count0), 64'd1);

    flushAll();
    for (int i = 0; i < 5; i++) pushEntry(18'h00081 + 18'(i), 1'b1, 1);
    popEntry();
    checkOutput("three queued count_o", 64'(count0), 64'd3);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 18'h0, 1);
    idle();
    checkOutput("flush+pop count_o", 64'(count0), 64'd0);
    checkOutput("flush+pop entry_o", 64'(entry0), 64'h0);
    checkOutput("flush+pop overflow_o", 64'(ovf0), 64'd0);

    for (int i = 0; i < 12; i++) begin
      pushEntry(18'h00100 + 18'(i), 1'b1, 1);
      popEntry();
      checkOutput("wrap pair entry_o", 64'(entry0), 64'h40100 + 64'(i));
    end

    for (int c = 0; c < 600; c++) begin
      rst     = ($urandom_range(0, 79) == 0);
      flush_i = ($urandom_range(0, 29) == 0);
      write_i = ($urandom_range(0, 2) != 0);
      read_i  = ($urandom_range(0, 2) == 0);
      make_i  = ($urandom_range(0, 3) != 0);
      entry_i = ($urandom_range(0, 9) == 0) ? 18'h3FFFF : 18'($urandom);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    flush_i = 1'b0;
    repeat (3) idle();
    #10;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
